// File: rtl/jtframe_vid_pkg.sv
// Shared raster constants: counter width and the default arcade timing (384x264, 256x224 visible).
// Overlays and benches import this package so that every stage agrees on one geometry.
package jtframe_vid_pkg;
  localparam int VID_W        = 9;
  localparam int DEF_CEN_DIV  = 4;
  localparam int DEF_HTOTAL   = 384;
  localparam int DEF_HVIS     = 256;
  localparam int DEF_HS_START = 288;
  localparam int DEF_HS_LEN   = 32;
  localparam int DEF_VTOTAL   = 264;
  localparam int DEF_VVIS     = 224;
  localparam int DEF_VS_START = 240;
  localparam int DEF_VS_LEN   = 3;

  typedef logic [VID_W-1:0] vid_cnt_t;
  // One bit wider than the counters so that start+len can reach 512.
  typedef logic [VID_W:0]   vid_cmp_t;

  function automatic logic in_win(input vid_cmp_t pos, input vid_cmp_t start, input vid_cmp_t len);
    return (pos >= start) && (pos < start + len);
  endfunction
endpackage

// File: rtl/jtframe_vid_cendiv.sv
// Pixel clock-enable divider: registered one-clk pulse every CEN_DIV clocks, no backpressure.
// With CEN_DIV=1 the pulse is high on every clock after reset.
module jtframe_vid_cendiv #(
  parameter int CEN_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pxl_cen
);
  localparam logic [3:0] LAST = 4'(CEN_DIV - 1);

  logic [3:0] div;
  logic [3:0] div_nxt;

  assign div_nxt = (div == LAST) ? 4'd0 : div + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= 4'd0;
      pxl_cen <= 1'b0;
    end else begin
      div     <= div_nxt;
      pxl_cen <= (div_nxt == LAST);
    end
  end
endmodule

// File: rtl/jtframe_vid_timing.sv
// Raster timing generator: counters, blanking, sync and frame markers, all registered with zero skew.
// pause freezes the raster (not a blank) while pxl_cen keeps running.
module jtframe_vid_timing
  import jtframe_vid_pkg::*;
#(
  parameter int CEN_DIV  = DEF_CEN_DIV,
  parameter int HTOTAL   = DEF_HTOTAL,
  parameter int HVIS     = DEF_HVIS,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_LEN   = DEF_HS_LEN,
  parameter int VTOTAL   = DEF_VTOTAL,
  parameter int VVIS     = DEF_VVIS,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_LEN   = DEF_VS_LEN,
  parameter bit BLKPOL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  output logic             pxl_cen,
  output logic [VID_W-1:0] hdump,
  output logic [VID_W-1:0] vdump,
  output logic             HB,
  output logic             VB,
  output logic             HS,
  output logic             VS,
  output logic             vinit,
  output logic             frame
);
  if (HVIS > HS_START)               begin : g_bad_hvis   $error("HVIS must not exceed HS_START");        end
  if (HS_START + HS_LEN > HTOTAL)    begin : g_bad_hs     $error("HS pulse runs past HTOTAL");            end
  if (VVIS > VS_START)               begin : g_bad_vvis   $error("VVIS must not exceed VS_START");        end
  if (VS_START + VS_LEN > VTOTAL)    begin : g_bad_vs     $error("VS pulse runs past VTOTAL");            end
  if (HTOTAL > 512)                  begin : g_bad_htot   $error("HTOTAL exceeds 9-bit counter");         end
  if (VTOTAL > 512)                  begin : g_bad_vtot   $error("VTOTAL exceeds 9-bit counter");         end
  if (CEN_DIV < 1 || CEN_DIV > 16)   begin : g_bad_cen    $error("CEN_DIV must be in 1..16");             end

  localparam vid_cnt_t H_LAST     = vid_cnt_t'(HTOTAL - 1);
  localparam vid_cnt_t V_LAST     = vid_cnt_t'(VTOTAL - 1);
  localparam vid_cmp_t HVIS_C     = vid_cmp_t'(HVIS);
  localparam vid_cmp_t VVIS_C     = vid_cmp_t'(VVIS);
  localparam vid_cmp_t HS_START_C = vid_cmp_t'(HS_START);
  localparam vid_cmp_t HS_LEN_C   = vid_cmp_t'(HS_LEN);
  localparam vid_cmp_t VS_START_C = vid_cmp_t'(VS_START);
  localparam vid_cmp_t VS_LEN_C   = vid_cmp_t'(VS_LEN);

  vid_cnt_t h_nxt;
  vid_cnt_t v_nxt;
  logic     adv;
  logic     at_origin;

  jtframe_vid_cendiv #(.CEN_DIV(CEN_DIV)) u_cendiv (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen)
  );

  assign adv = pxl_cen & ~pause;

  always_comb begin
    h_nxt = hdump + vid_cnt_t'(1);
    v_nxt = vdump;
    if (hdump == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vdump == V_LAST) ? '0 : vdump + vid_cnt_t'(1);
    end
  end

  assign at_origin = (h_nxt == '0) && (v_nxt == '0);

  // Decode from the next counter values so flags land on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdump <= '0;
      vdump <= '0;
      HB    <= ~BLKPOL;
      VB    <= ~BLKPOL;
      HS    <= 1'b0;
      VS    <= 1'b0;
      vinit <= 1'b0;
      frame <= 1'b0;
    end else if (adv) begin
      hdump <= h_nxt;
      vdump <= v_nxt;
      HB    <= (vid_cmp_t'(h_nxt) >= HVIS_C) ^ ~BLKPOL;
      VB    <= (vid_cmp_t'(v_nxt) >= VVIS_C) ^ ~BLKPOL;
      HS    <= in_win(vid_cmp_t'(h_nxt), HS_START_C, HS_LEN_C);
      VS    <= in_win(vid_cmp_t'(v_nxt), VS_START_C, VS_LEN_C);
      vinit <= at_origin;
      if (at_origin) frame <= ~frame;
    end
  end
endmodule

// File: tb/tb_jtframe_vid_timing.sv
// Directed bench: default timing with pause/reset, scaled geometries for full frames and BLKPOL=0,
// and a tiny CEN_DIV=1 raster checked every clock against a closed-form position model.
module tb_jtframe_vid_timing;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, pause_a = 1'b0, rst_b = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, done2 = 1'b0;
  int   ta = 0, tb = 0;
  int   n_tests = 0, n_fail = 0;

  logic       cen_a, cen_b, cen_c, cen_d;
  logic [8:0] h_a, v_a, h_b, v_b, h_c, v_c, h_d, v_d;
  logic       hb_a, vb_a, hs_a, vs_a, vin_a, frm_a;
  logic       hb_b, vb_b, hs_b, vs_b, vin_b, frm_b;
  logic       hb_c, vb_c, hs_c, vs_c, vin_c, frm_c;
  logic       hb_d, vb_d, hs_d, vs_d, vin_d, frm_d;

  jtframe_vid_timing u_a (
    .clk(clk), .rst(rst_a), .pause(pause_a), .pxl_cen(cen_a), .hdump(h_a), .vdump(v_a),
    .HB(hb_a), .VB(vb_a), .HS(hs_a), .VS(vs_a), .vinit(vin_a), .frame(frm_a));

  jtframe_vid_timing #(.CEN_DIV(2), .HTOTAL(48), .HVIS(32), .HS_START(36), .HS_LEN(4),
    .VTOTAL(20), .VVIS(16), .VS_START(17), .VS_LEN(2), .BLKPOL(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .pause(1'b0), .pxl_cen(cen_b), .hdump(h_b), .vdump(v_b),
    .HB(hb_b), .VB(vb_b), .HS(hs_b), .VS(vs_b), .vinit(vin_b), .frame(frm_b));

  jtframe_vid_timing #(.CEN_DIV(2), .HTOTAL(48), .HVIS(32), .HS_START(36), .HS_LEN(4),
    .VTOTAL(20), .VVIS(16), .VS_START(17), .VS_LEN(2), .BLKPOL(1'b0)) u_c (
    .clk(clk), .rst(rst_b), .pause(1'b0), .pxl_cen(cen_c), .hdump(h_c), .vdump(v_c),
    .HB(hb_c), .VB(vb_c), .HS(hs_c), .VS(vs_c), .vinit(vin_c), .frame(frm_c));

  jtframe_vid_timing #(.CEN_DIV(1), .HTOTAL(8), .HVIS(4), .HS_START(5), .HS_LEN(1),
    .VTOTAL(4), .VVIS(2), .VS_START(3), .VS_LEN(1), .BLKPOL(1'b1)) u_d (
    .clk(clk), .rst(rst_b), .pause(1'b0), .pxl_cen(cen_d), .hdump(h_d), .vdump(v_d),
    .HB(hb_d), .VB(vb_d), .HS(hs_d), .VS(vs_d), .vinit(vin_d), .frame(frm_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {pxl_cen,hdump,vdump,HB,VB,HS,VS,vinit,frame} t clocks after reset, no pause.
  function automatic logic [24:0] exp_raster(input int t, input int cdiv, input int htot, input int hvis,
      input int hss, input int hsl, input int vtot, input int vvis, input int vss, input int vsl, input bit pol);
    int p, h, v, fr;
    logic cen, hb, vb, hs, vs, vi, fm;
    p = t / cdiv;
    if (cdiv == 1 && t >= 1) p = t - 1;
    cen = (t >= 1) && ((t % cdiv) == cdiv - 1);
    fr  = htot * vtot;
    h   = p % htot;
    v   = (p / htot) % vtot;
    hb  = (h >= hvis) ^ !pol;
    vb  = (v >= vvis) ^ !pol;
    hs  = (h >= hss) && (h < hss + hsl);
    vs  = (v >= vss) && (v < vss + vsl);
    vi  = (p > 0) && ((p % fr) == 0);
    fm  = ((p / fr) % 2) == 1;
    return {cen, 9'(h), 9'(v), hb, vb, hs, vs, vi, fm};
  endfunction

  always @(posedge clk) begin
    ta <= rst_a ? 0 : ta + 1;
    tb <= rst_b ? 0 : tb + 1;
  end

  always @(negedge clk) begin
    if (en_a) check("ras_a", {cen_a, h_a, v_a, hb_a, vb_a, hs_a, vs_a, vin_a, frm_a},
                    exp_raster(ta, 4, 384, 256, 288, 32, 264, 224, 240, 3, 1'b1));
    if (en_b) begin
      check("ras_b", {cen_b, h_b, v_b, hb_b, vb_b, hs_b, vs_b, vin_b, frm_b},
            exp_raster(tb, 2, 48, 32, 36, 4, 20, 16, 17, 2, 1'b1));
      check("ras_c", {cen_c, h_c, v_c, hb_c, vb_c, hs_c, vs_c, vin_c, frm_c},
            exp_raster(tb, 2, 48, 32, 36, 4, 20, 16, 17, 2, 1'b0));
      check("ras_d", {cen_d, h_d, v_d, hb_d, vb_d, hs_d, vs_d, vin_d, frm_d},
            exp_raster(tb, 1, 8, 4, 5, 1, 4, 2, 3, 1, 1'b1));
    end
  end

  task automatic wait_a(input int hh, input int vv, input int budget, input string tag);
    int n;
    n = 0;
    while (!(h_a == 9'(hh) && v_a == 9'(vv)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (h_a == 9'(hh) && v_a == 9'(vv)), 1);
  endtask

  initial begin : proc_a
    int n, nhs, ncen, nvin;
    logic prev_hs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hdump", h_a, 0);
    check("rst_vdump", v_a, 0);
    check("rst_cen", cen_a, 0);
    check("rst_hb", hb_a, 0);
    check("rst_vb", vb_a, 0);
    check("rst_hs_vs", {hs_a, vs_a}, 0);
    check("rst_vinit_frame", {vin_a, frm_a}, 0);
    check("rst_hb_vb_pol0", {hb_c, vb_c}, 2'b11);
    rst_a = 1'b0;
    rst_b = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;

    wait_a(255, 0, 2000, "a_reach_255");
    check("a_hb_at_255", hb_a, 0);
    @(negedge clk);
    wait_a(256, 0, 8, "a_reach_256");
    check("a_hb_rise_256", hb_a, 1);

    nhs = 0; n = 0; prev_hs = hs_a;
    while (!(h_a == 9'd0 && v_a == 9'd1) && n < 1000) begin
      @(negedge clk);
      n++;
      if (cen_a && hs_a) nhs++;
      if (hs_a && !prev_hs) check("a_hs_rise_h", h_a, 288);
      if (!hs_a && prev_hs) check("a_hs_fall_h", h_a, 320);
      prev_hs = hs_a;
    end
    check("a_reach_line1", (h_a == 9'd0 && v_a == 9'd1), 1);
    check("a_hs_width", nhs, 32);
    check("a_hb_fall_h0", hb_a, 0);

    wait_a(100, 1, 1000, "a_reach_pause_pt");
    pause_a = 1'b1;
    en_a    = 1'b0;
    ncen    = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cen_a) ncen++;
      check("a_pause_hold", {h_a, v_a, hb_a, vb_a, hs_a, vs_a, vin_a, frm_a}, {9'd100, 9'd1, 6'b000000});
    end
    check("a_pause_cen_count", ncen, 250);
    pause_a = 1'b0;
    n = 0;
    while (!cen_a && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("a_cen_after_pause", cen_a, 1);
    check("a_hold_until_cen", h_a, 100);
    @(negedge clk);
    check("a_resume_h101", h_a, 101);

    wait_a(300, 1, 2000, "a_reach_300");
    check("a_hs_at_300", hs_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_mrst_hv", {h_a, v_a}, 0);
    check("a_mrst_flags", {cen_a, hb_a, vb_a, hs_a, vs_a, vin_a}, 0);
    rst_a = 1'b0;
    en_a  = 1'b1;
    nvin  = 0;
    repeat (500) begin
      @(negedge clk);
      if (vin_a) nvin++;
    end
    check("a_no_vinit_after_rst", nvin, 0);

    n = 0;
    while (!done2 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("bcd_done", done2, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : proc_bcd
    int n, t0, ncen, vs_rises;
    logic prev_vb, prev_vs, prev_hs, prev_vin, rise;
    @(negedge rst_b);
    n = 0;
    while (!vin_d && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("d_vinit1_seen", vin_d, 1);
    check("d_cen_high", cen_d, 1);
    t0 = tb;
    n  = 0;
    @(negedge clk);
    while (!vin_d && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("d_vinit_period", tb - t0, 32);

    n = 0;
    while (!vin_b && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("b_vinit1_seen", vin_b, 1);
    check("b_frame_first", frm_b, 1);
    check("b_vinit_at_origin", {h_b, v_b}, 0);
    ncen = 0; n = 0; vs_rises = 0;
    prev_vb = vb_b; prev_vs = vs_b; prev_hs = hs_b; prev_vin = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (cen_b) ncen++;
      if (vb_b != prev_vb) begin
        check("b_vb_edge_h0", h_b, 0);
        check("b_vb_edge_line", v_b, vb_b ? 16 : 0);
      end
      if (vs_b != prev_vs) begin
        check("b_vs_edge_h0", h_b, 0);
        check("b_vs_edge_line", v_b, vs_b ? 17 : 19);
        if (vs_b) vs_rises++;
      end
      if (hs_b && !prev_hs) check("b_hs_rise_h", h_b, 36);
      if (!hs_b && prev_hs) check("b_hs_fall_h", h_b, 40);
      rise = vin_b && !prev_vin;
      prev_vb = vb_b; prev_vs = vs_b; prev_hs = hs_b; prev_vin = vin_b;
    end while (!rise && n < 4000);
    check("b_vinit2_seen", vin_b, 1);
    check("b_cen_per_frame", ncen, 960);
    check("b_frame_second", frm_b, 0);
    check("b_vs_pulses", vs_rises, 1);
    check("c_origin_not_blank", {hb_c, vb_c}, 2'b11);
    done2 = 1'b1;
  end
endmodule

// File: doc/jtframe_vid_timing.md
Name: jtframe_vid_timing

Overview:
- Programmable raster timing generator that drives the pixel-rate stages of the video chain, including the credits/pause overlay directly downstream.
- Produces the pixel clock enable, H/V blanking, H/V sync, raster counters and frame markers from the single system clock.
- Every output is registered and coherent: blanking and sync always describe the hdump/vdump value presented in the same cycle.

Parameters:
- CEN_DIV, 4, system clocks per pixel; legal range 1..16.
- HTOTAL, 384, pixels per line.
- HVIS, 256, visible pixels per line (0..HVIS-1).
- HS_START, 288, first pixel with HS active.
- HS_LEN, 32, HS width in pixels.
- VTOTAL, 264, lines per frame.
- VVIS, 224, visible lines per frame (0..VVIS-1).
- VS_START, 240, first line with VS active.
- VS_LEN, 3, VS width in lines.
- BLKPOL, 1, HB/VB polarity; 1 means active high. Sync outputs are always active high.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pause  in  1  while high, counters hold and pxl_cen keeps running
- pxl_cen  out  1  one-clk pulse every CEN_DIV clocks
- hdump  out  9  horizontal counter, 0..HTOTAL-1
- vdump  out  9  vertical counter, 0..VTOTAL-1
- HB  out  1  horizontal blank, polarity set by BLKPOL
- VB  out  1  vertical blank, polarity set by BLKPOL
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- vinit  out  1  one-pxl_cen-wide pulse at hdump=0, vdump=0
- frame  out  1  toggles at each vinit

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values:
  - divider=0, pxl_cen=0, hdump=0, vdump=0
  - HB=VB=~BLKPOL (not blanking); HS=VS=0
  - vinit=0, frame=0
  - Reset asserted mid-frame applies the same values on the next edge. No partial line is finished.
- Divider:
  - Counts 0..CEN_DIV-1 and wraps.
  - pxl_cen=1 on the clk where the divider equals CEN_DIV-1.
  - With CEN_DIV=1, pxl_cen is 1 on every clk after reset; the first pulse arrives on the first clk after rst falls.
- Counters advance only on pxl_cen=1 and only when pause=0:
  - hdump = hdump+1. At HTOTAL-1 it wraps to 0 and vdump increments.
  - At hdump wrap with vdump=VTOTAL-1, vdump also wraps to 0.
- Derived outputs:
  - Computed from the next counter values and registered on the same edge as the counters, so latency relative to hdump/vdump is 0.
  - hb_int = hdump>=HVIS; HB = hb_int ^ ~BLKPOL.
  - vb_int = vdump>=VVIS; VB likewise. VB changes only together with an hdump wrap.
  - HS = HS_START <= hdump < HS_START+HS_LEN.
  - VS = VS_START <= vdump < VS_START+VS_LEN; it changes at hdump=0.
- vinit:
  - Asserted on the edge where the counters become (0,0).
  - Cleared on the next pxl_cen edge that advances the counters.
  - frame toggles on that same edge.
  - vinit does not assert on reset release.
- Pause:
  - Counters and all derived outputs freeze and pxl_cen continues.
  - If vinit is high when pause rises, it stays high until counting resumes and the counters advance.
  - Downstream stages see a frozen raster. Pause is not a blank.
- Parameter checks (simulation only, $error at time 0, no synthesis logic):
  - HVIS<=HS_START
  - HS_START+HS_LEN<=HTOTAL
  - VVIS<=VS_START
  - VS_START+VS_LEN<=VTOTAL
  - HTOTAL<=512
  - VTOTAL<=512
  - 1<=CEN_DIV<=16
- Width rules:
  - Comparisons are done at 10 bits so HS_START+HS_LEN=512 cannot overflow.
  - Counter increments are 9-bit with an explicit wrap compare, never a natural overflow.

Decomposition:
- Shared package jtframe_vid_pkg: 9-bit counter width constant and default timing constants (HTOTAL/HVIS/VTOTAL/VVIS and sync values), reused by overlays and test benches.
- One sub-module: jtframe_vid_cendiv, the divider that produces pxl_cen with a synchronous reset. The raster counters and decode stay in the top module.

Test Plan:
- Defaults, free run for 2 frames: pxl_cen period=4 clk; exactly 384×264 pxl_cen pulses between vinit pulses; frame toggles 0->1->0.
- Blanking edges: HB rises with hdump=256 and falls with hdump=0; VB rises on the hdump wrap into vdump=224 and falls into vdump=0; BLKPOL=0 run shows inverted HB/VB.
- Sync: HS high for exactly 32 pxl_cen across hdump 288..319; VS high for lines 240..242 only; VS changes coincide with hdump=0.
- Pause at hdump=100, vdump=50 for 1000 clk: hdump/vdump/HB/VB/HS/VS constant and pxl_cen keeps pulsing; on release, next pxl_cen gives hdump=101.
- Reset mid-line at hdump=300 with HS=1, held 1 clk: next edge gives hdump=0, vdump=0, HS=0, HB=VB inactive, pxl_cen=0; the first vinit comes only after a full frame.
- CEN_DIV=1, HTOTAL=8, HVIS=4, VTOTAL=4, VVIS=2, HS_START=5, HS_LEN=1, VS_START=3, VS_LEN=1: pxl_cen stays high; vinit period=32 clk; sequence matches the cycle-accurate model.
